// File: rtl/control_fsm.sv
`default_nettype none
// ============================================================================
// Module  : control_fsm
// Purpose : Multicycle control sequencer for the 16-bit CPU datapath.
// Rev     : 1.0  initial release
// ============================================================================
module control_fsm #(
    parameter int RET_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       op,
    input  logic [2:0]       funk,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             BranchNe,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic [1:0]       RegDst,
    output logic [1:0]       MemtoReg,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             halted,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [RET_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MADDR  = 4'd2,
        S_MRD    = 4'd3,
        S_MWB    = 4'd4,
        S_MWR    = 4'd5,
        S_EXR    = 4'd6,
        S_RWB    = 4'd7,
        S_EXI    = 4'd8,
        S_IWB    = 4'd9,
        S_BR     = 4'd10,
        S_JMP    = 4'd11,
        S_HALT   = 4'd12,
        S_ILL    = 4'd13
    } state_t;

    state_t cur_state;
    state_t nxt_state;
    logic   is_sw;
    logic   is_bne;
    logic   is_jal;
    logic   retire;

    // Instruction flavour flags are captured in DECODE so later states never read op.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur_state <= S_FETCH;
            retired   <= '0;
            is_sw     <= 1'b0;
            is_bne    <= 1'b0;
            is_jal    <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            if (cur_state == S_DECODE) begin
                is_sw  <= (op == 4'h3);
                is_bne <= (op == 4'h5);
                is_jal <= (op == 4'h7);
            end
            if (retire) begin
                retired <= retired + RET_W'(1);
            end
        end
    end

    assign state   = cur_state;
    assign halted  = (cur_state == S_HALT);
    assign illegal = (cur_state == S_ILL);

    always_comb begin
        nxt_state   = cur_state;
        retire      = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchNe    = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 2'b00;
        MemtoReg    = 2'b00;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 3'b000;
        PCSource    = 2'b00;
        case (cur_state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                // The PC/IR loads are gated off while reset is held so nothing commits.
                IRWrite = mem_ready & ~reset;
                PCWrite = mem_ready & ~reset;
                if (mem_ready) begin
                    nxt_state = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (op)
                    4'h0:       nxt_state = (funk == 3'd7) ? S_ILL : S_EXR;
                    4'h1:       nxt_state = S_EXI;
                    4'h2, 4'h3: nxt_state = S_MADDR;
                    4'h4, 4'h5: nxt_state = S_BR;
                    4'h6, 4'h7: nxt_state = S_JMP;
                    4'hF:       nxt_state = S_HALT;
                    default:    nxt_state = S_ILL;
                endcase
            end
            S_MADDR: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                nxt_state = is_sw ? S_MWR : S_MRD;
            end
            S_MRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) begin
                    nxt_state = S_MWB;
                end
            end
            S_MWB: begin
                RegWrite  = 1'b1;
                MemtoReg  = 2'b01;
                nxt_state = S_FETCH;
                retire    = 1'b1;
            end
            S_MWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) begin
                    nxt_state = S_FETCH;
                    retire    = 1'b1;
                end
            end
            S_EXR: begin
                ALUSrcA   = 1'b1;
                ALUOp     = funk;
                nxt_state = S_RWB;
            end
            S_RWB: begin
                RegWrite  = 1'b1;
                RegDst    = 2'b01;
                nxt_state = S_FETCH;
                retire    = 1'b1;
            end
            S_EXI: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                nxt_state = S_IWB;
            end
            S_IWB: begin
                RegWrite  = 1'b1;
                nxt_state = S_FETCH;
                retire    = 1'b1;
            end
            S_BR: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 3'b001;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                BranchNe    = is_bne;
                nxt_state   = S_FETCH;
                retire      = 1'b1;
            end
            S_JMP: begin
                PCWrite   = 1'b1;
                PCSource  = 2'b10;
                if (is_jal) begin
                    RegWrite = 1'b1;
                    RegDst   = 2'b10;
                    MemtoReg = 2'b10;
                end
                nxt_state = S_FETCH;
                retire    = 1'b1;
            end
            S_HALT:  nxt_state = S_HALT;
            S_ILL:   nxt_state = S_ILL;
            default: nxt_state = S_FETCH;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_control_fsm.sv
`default_nettype none
// ============================================================================
// Module  : tb_control_fsm
// Purpose : Self-checking bench for control_fsm against an instruction-level model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_control_fsm;

    localparam int RET_W = 16;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [3:0]       op = 4'h0;
    logic [2:0]       funk = 3'd0;
    logic             mem_ready = 1'b0;
    logic             PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite, RegWrite;
    logic [1:0]       RegDst, MemtoReg, ALUSrcB, PCSource;
    logic             ALUSrcA, halted, illegal;
    logic [2:0]       ALUOp;
    logic [3:0]       state;
    logic [RET_W-1:0] retired;

    control_fsm #(.RET_W(RET_W)) dut (
        .clock(clock), .reset(reset), .op(op), .funk(funk), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNe(BranchNe), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .PCSource(PCSource), .halted(halted), .illegal(illegal),
        .state(state), .retired(retired)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       pc_write, pc_write_cond, branch_ne, iord;
        logic       mem_read, mem_write, ir_write, reg_write;
        logic [1:0] reg_dst, memto_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       halted, illegal;
    } ctrl_t;

    ctrl_t dut_c;
    assign dut_c = {PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite, RegWrite,
                    RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource, halted, illegal};

    int               total = 0;
    int               bad   = 0;
    logic [RET_W-1:0] model_ret = '0;
    logic [3:0]       cur_op;
    logic [2:0]       cur_funk;
    logic [3:0]       exp_st[$];
    bit               exp_mr[$];
    logic [3:0]       obs_st[$];
    ctrl_t            obs_c[$];

    // Control word the table of state behaviours calls for.
    function automatic ctrl_t exp_ctrl(input logic [3:0] st, input logic [3:0] o,
                                       input logic [2:0] f, input bit mr);
        ctrl_t c;
        c = '0;
        case (st)
            4'd0:       begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = mr; c.pc_write = mr; end
            4'd1:       c.alu_src_b = 2'b11;
            4'd2, 4'd8: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            4'd3:       begin c.mem_read = 1; c.iord = 1; end
            4'd4:       begin c.reg_write = 1; c.memto_reg = 2'b01; end
            4'd5:       begin c.mem_write = 1; c.iord = 1; end
            4'd6:       begin c.alu_src_a = 1; c.alu_op = f; end
            4'd7:       begin c.reg_write = 1; c.reg_dst = 2'b01; end
            4'd9:       c.reg_write = 1;
            4'd10: begin
                c.alu_src_a = 1; c.alu_op = 3'b001; c.pc_write_cond = 1;
                c.pc_source = 2'b01; c.branch_ne = (o == 4'h5);
            end
            4'd11: begin
                c.pc_write = 1; c.pc_source = 2'b10;
                if (o == 4'h7) begin c.reg_write = 1; c.reg_dst = 2'b10; c.memto_reg = 2'b10; end
            end
            4'd12:   c.halted = 1;
            4'd13:   c.illegal = 1;
            default: ;
        endcase
        return c;
    endfunction

    task automatic push(input int s, input bit m);
        exp_st.push_back(4'(s));
        exp_mr.push_back(m);
    endtask

    // Instruction-level model: the cycle-by-cycle state path and memory handshake.
    task automatic plan(input logic [3:0] o, input logic [2:0] f, input int fw, input int mw);
        cur_op   = o;
        cur_funk = f;
        exp_st.delete();
        exp_mr.delete();
        for (int i = 0; i < fw; i++) push(0, 0);
        push(0, 1);
        push(1, bit'($urandom_range(0, 1)));
        case (o)
            4'h0: if (f == 3'd7) push(13, 1); else begin push(6, 1); push(7, 0); end
            4'h1: begin push(8, 0); push(9, 1); end
            4'h2: begin
                push(2, 0);
                for (int i = 0; i < mw; i++) push(3, 0);
                push(3, 1);
                push(4, 0);
            end
            4'h3: begin
                push(2, 1);
                for (int i = 0; i < mw; i++) push(5, 0);
                push(5, 1);
            end
            4'h4, 4'h5: push(10, bit'($urandom_range(0, 1)));
            4'h6, 4'h7: push(11, bit'($urandom_range(0, 1)));
            4'hF:       push(12, 1);
            default:    push(13, 1);
        endcase
        if (o <= 4'h7 && !(o == 4'h0 && f == 3'd7)) model_ret = model_ret + 1'b1;
    endtask

    task automatic drive_instr();
        obs_st.delete();
        obs_c.delete();
        op   = cur_op;
        funk = cur_funk;
        for (int i = 0; i < exp_mr.size(); i++) begin
            mem_ready = exp_mr[i];
            #1;
            obs_st.push_back(state);
            obs_c.push_back(dut_c);
            @(negedge clock);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mem_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_ret = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mem_ready = 1'b1;
        @(negedge clock);
        #1;
        total++;
        if (state !== 4'd0 || retired !== '0 || halted !== 1'b0 || illegal !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: state=%0d retired=%0d halted=%b illegal=%b, want 0/0/0/0",
                     state, retired, halted, illegal);
        end
        total++;
        if (MemRead !== 1'b1 || IRWrite !== 1'b0 || PCWrite !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: MemRead=%b IRWrite=%b PCWrite=%b, want 1/0/0",
                     MemRead, IRWrite, PCWrite);
        end
        @(negedge clock);
        reset = 1'b0;
        model_ret = '0;
    endtask

    task automatic test_sub();
        plan(4'h0, 3'd1, 0, 0);
        drive_instr();
        for (int i = 0; i < exp_st.size(); i++) begin
            total++;
            if (obs_st[i] !== exp_st[i] || obs_c[i] !== exp_ctrl(exp_st[i], cur_op, cur_funk, exp_mr[i])) begin
                bad++;
                $display("FAIL sub cycle %0d: state=%0d ctrl=%h, want state=%0d ctrl=%h", i, obs_st[i],
                         obs_c[i], exp_st[i], exp_ctrl(exp_st[i], cur_op, cur_funk, exp_mr[i]));
            end
        end
        total++;
        if (retired !== model_ret) begin
            bad++;
            $display("FAIL sub_retired: got %0d want %0d", retired, model_ret);
        end
    endtask

    task automatic test_lw_wait();
        plan(4'h2, 3'd0, 1, 3);
        drive_instr();
        for (int i = 0; i < exp_st.size(); i++) begin
            total++;
            if (obs_st[i] !== exp_st[i] || obs_c[i] !== exp_ctrl(exp_st[i], cur_op, cur_funk, exp_mr[i])) begin
                bad++;
                $display("FAIL lw cycle %0d: state=%0d ctrl=%h, want state=%0d ctrl=%h", i, obs_st[i],
                         obs_c[i], exp_st[i], exp_ctrl(exp_st[i], cur_op, cur_funk, exp_mr[i]));
            end
        end
        total++;
        if (retired !== model_ret) begin
            bad++;
            $display("FAIL lw_retired: got %0d want %0d", retired, model_ret);
        end
    endtask

    task automatic test_branch_jump();
        logic [3:0] ops[3] = '{4'h4, 4'h5, 4'h7};
        for (int k = 0; k < 3; k++) begin
            plan(ops[k], 3'd0, 0, 0);
            drive_instr();
            for (int i = 0; i < exp_st.size(); i++) begin
                total++;
                if (obs_st[i] !== exp_st[i] || obs_c[i] !== exp_ctrl(exp_st[i], cur_op, cur_funk, exp_mr[i])) begin
                    bad++;
                    $display("FAIL branch_jump op=%0h cycle %0d: state=%0d ctrl=%h, want state=%0d ctrl=%h",
                             cur_op, i, obs_st[i], obs_c[i], exp_st[i],
                             exp_ctrl(exp_st[i], cur_op, cur_funk, exp_mr[i]));
                end
            end
            total++;
            if (state !== 4'd0 || retired !== model_ret) begin
                bad++;
                $display("FAIL branch_jump_next op=%0h: state=%0d retired=%0d, want 0/%0d",
                         cur_op, state, retired, model_ret);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] o;
        logic [2:0] f;
        for (int n = 0; n < 40; n++) begin
            o = 4'($urandom_range(0, 7));
            f = (o == 4'h0) ? 3'($urandom_range(0, 6)) : 3'($urandom_range(0, 7));
            plan(o, f, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
            drive_instr();
            for (int i = 0; i < exp_st.size(); i++) begin
                total++;
                if (obs_st[i] !== exp_st[i] || obs_c[i] !== exp_ctrl(exp_st[i], cur_op, cur_funk, exp_mr[i])) begin
                    bad++;
                    $display("FAIL random #%0d op=%0h funk=%0d cycle %0d: state=%0d ctrl=%h, want state=%0d ctrl=%h",
                             n, o, f, i, obs_st[i], obs_c[i], exp_st[i],
                             exp_ctrl(exp_st[i], cur_op, cur_funk, exp_mr[i]));
                end
            end
            total++;
            if (retired !== model_ret) begin
                bad++;
                $display("FAIL random_retired #%0d: got %0d want %0d", n, retired, model_ret);
            end
        end
    endtask

    task automatic test_halt_illegal();
        logic [3:0] ops[3]   = '{4'hF, 4'h0, 4'h9};
        logic [2:0] funks[3] = '{3'd0, 3'd7, 3'd0};
        logic [3:0] want_st;
        for (int k = 0; k < 3; k++) begin
            do_reset();
            plan(4'h1, 3'd0, 0, 0);
            drive_instr();
            plan(ops[k], funks[k], 0, 0);
            drive_instr();
            want_st = (ops[k] == 4'hF) ? 4'd12 : 4'd13;
            for (int i = 0; i < 12; i++) begin
                mem_ready = 1'($urandom_range(0, 1));
                #1;
                total++;
                if (state !== want_st || halted !== (want_st == 4'd12) || illegal !== (want_st == 4'd13)
                    || retired !== model_ret || RegWrite !== 1'b0 || MemRead !== 1'b0) begin
                    bad++;
                    $display("FAIL stop op=%0h funk=%0d cycle %0d: state=%0d halted=%b illegal=%b retired=%0d, want %0d/%b/%b/%0d",
                             ops[k], funks[k], i, state, halted, illegal, retired, want_st,
                             want_st == 4'd12, want_st == 4'd13, model_ret);
                end
                @(negedge clock);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        plan(4'h1, 3'd0, 0, 0);
        drive_instr();
        op = 4'h3;
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) @(negedge clock);
        mem_ready = 1'b0;
        #1;
        total++;
        if (state !== 4'd5 || MemWrite !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_mwr: state=%0d MemWrite=%b, want 5/1", state, MemWrite);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if (state !== 4'd0 || retired !== '0 || MemWrite !== 1'b0 || MemRead !== 1'b1) begin
            bad++;
            $display("FAIL async_reset_mwr: state=%0d retired=%0d MemWrite=%b MemRead=%b, want 0/0/0/1",
                     state, retired, MemWrite, MemRead);
        end
        @(posedge clock);
        #1;
        total++;
        if (state !== 4'd0 || MemWrite !== 1'b0) begin
            bad++;
            $display("FAIL reset_next_edge: state=%0d MemWrite=%b, want 0/0", state, MemWrite);
        end
        @(negedge clock);
        reset = 1'b0;
        model_ret = '0;
        plan(4'h1, 3'd0, 0, 0);
        drive_instr();
        plan(4'hF, 3'd0, 0, 0);
        drive_instr();
        #2 reset = 1'b1;
        #1;
        total++;
        if (state !== 4'd0 || halted !== 1'b0 || retired !== '0) begin
            bad++;
            $display("FAIL async_reset_halt: state=%0d halted=%b retired=%0d, want 0/0/0",
                     state, halted, retired);
        end
        @(negedge clock);
        reset = 1'b0;
        model_ret = '0;
        plan(4'h0, 3'd2, 0, 0);
        drive_instr();
        for (int i = 0; i < exp_st.size(); i++) begin
            total++;
            if (obs_st[i] !== exp_st[i] || obs_c[i] !== exp_ctrl(exp_st[i], cur_op, cur_funk, exp_mr[i])) begin
                bad++;
                $display("FAIL post_reset cycle %0d: state=%0d ctrl=%h, want state=%0d ctrl=%h", i,
                         obs_st[i], obs_c[i], exp_st[i], exp_ctrl(exp_st[i], cur_op, cur_funk, exp_mr[i]));
            end
        end
        total++;
        if (retired !== model_ret) begin
            bad++;
            $display("FAIL post_reset_retired: got %0d want %0d", retired, model_ret);
        end
    endtask

    initial begin
        test_reset();
        test_sub();
        test_lw_wait();
        test_branch_jump();
        test_random();
        test_halt_illegal();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
